// File: rtl/pfd_cp_sampled.sv
// Clock-sampled tri-state phase-frequency detector with a real-valued charge-pump output.
// The reference input is named ref_clk because "ref" is a reserved word in SystemVerilog.
module pfd_cp_sampled #(
  parameter real Icp      = 100e-6,
  parameter real MISMATCH = 0.0,
  parameter real Ileak    = 0.0,
  parameter int  RST_DLY  = 2,
  parameter int  LOCK_WIN = 2,
  parameter int  LOCK_CNT = 64
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       en,
  input  logic       ref_clk,
  input  logic       fb,
  output logic       up,
  output logic       dn,
  output real        si,
  output logic       lock,
  output logic [7:0] slip_cnt
);

  typedef enum logic [1:0] {IDLE, UP, DN, BOTH} state_t;

  state_t      state, state_nx;
  logic [2:0]  ref_sync, fb_sync;
  logic        rise_ref, rise_fb;
  logic        pend_ref, pend_fb, pend_ref_nx, pend_fb_nx;
  logic        pr, pf;
  logic [3:0]  dcnt, dcnt_nx;
  logic [7:0]  wcnt, lcnt;
  logic        slip, enter_both, is_updn, is_updn_nx, bad, up_nx, dn_nx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  // Synchroniser: bit 0 is s1, bit 2 is s3
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ref_sync <= 3'b000;
      fb_sync  <= 3'b000;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_clk};
      fb_sync  <= {fb_sync[1:0], fb};
    end
  end

  assign rise_ref = ref_sync[1] & ~ref_sync[2];
  assign rise_fb  = fb_sync[1] & ~fb_sync[2];

  // Next-state decode
  always_comb begin
    state_nx    = state;
    pend_ref_nx = pend_ref;
    pend_fb_nx  = pend_fb;
    dcnt_nx     = dcnt;
    slip        = 1'b0;
    enter_both  = 1'b0;
    pr          = pend_ref | rise_ref;
    pf          = pend_fb | rise_fb;
    case (state)
      IDLE: begin
        if (rise_ref && rise_fb) begin
          state_nx   = BOTH;
          enter_both = 1'b1;
        end else if (rise_ref) begin
          state_nx = UP;
        end else if (rise_fb) begin
          state_nx = DN;
        end
      end
      UP: begin
        if (rise_fb) begin
          state_nx   = BOTH;
          enter_both = 1'b1;
        end else if (rise_ref) begin
          slip = 1'b1;
        end
      end
      DN: begin
        if (rise_ref) begin
          state_nx   = BOTH;
          enter_both = 1'b1;
        end else if (rise_fb) begin
          slip = 1'b1;
        end
      end
      BOTH: begin
        if (dcnt == 4'(RST_DLY - 1)) begin
          dcnt_nx     = 4'd0;
          pend_ref_nx = 1'b0;
          pend_fb_nx  = 1'b0;
          if (pr && pf) begin
            state_nx   = BOTH;
            enter_both = 1'b1;
          end else if (pr) begin
            state_nx = UP;
          end else if (pf) begin
            state_nx = DN;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          dcnt_nx     = dcnt + 4'd1;
          pend_ref_nx = pr;
          pend_fb_nx  = pf;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!en) begin
      state_nx    = IDLE;
      pend_ref_nx = 1'b0;
      pend_fb_nx  = 1'b0;
      dcnt_nx     = 4'd0;
      slip        = 1'b0;
      enter_both  = 1'b0;
    end
  end

  assign is_updn    = (state == UP) || (state == DN);
  assign is_updn_nx = (state_nx == UP) || (state_nx == DN);
  assign up_nx      = (state_nx == UP) || (state_nx == BOTH);
  assign dn_nx      = (state_nx == DN) || (state_nx == BOTH);
  // An over-long pulse breaks lock as soon as it exceeds the window, not only at its end
  assign bad        = slip | (is_updn & (wcnt > 8'(LOCK_WIN)));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= IDLE;
      pend_ref <= 1'b0;
      pend_fb  <= 1'b0;
      dcnt     <= 4'd0;
      wcnt     <= 8'd0;
      lcnt     <= 8'd0;
      slip_cnt <= 8'd0;
      si       <= 0.0;
    end else begin
      state    <= state_nx;
      pend_ref <= pend_ref_nx;
      pend_fb  <= pend_fb_nx;
      dcnt     <= dcnt_nx;
      wcnt     <= is_updn_nx ? (is_updn ? sat_inc(wcnt, 8'hFF) : 8'd1) : 8'd0;
      if (!en || bad)
        lcnt <= 8'd0;
      else if (enter_both && (wcnt <= 8'(LOCK_WIN)))
        lcnt <= sat_inc(lcnt, 8'(LOCK_CNT));
      if (slip)
        slip_cnt <= sat_inc(slip_cnt, 8'hFF);
      if (!en)
        si <= 0.0;
      else
        si <= (up_nx ? Icp : 0.0) - (dn_nx ? Icp * (1.0 + MISMATCH) : 0.0) + Ileak;
    end
  end

  assign up   = (state == UP) || (state == BOTH);
  assign dn   = (state == DN) || (state == BOTH);
  assign lock = (lcnt == 8'(LOCK_CNT));

endmodule

// File: tb/tb_pfd_cp_sampled.sv
// Bench for pfd_cp_sampled: a default instance and a 10% DN-mismatch instance share stimulus.
module tb_pfd_cp_sampled;

  logic       clk = 1'b0;
  logic       rstb, en, ref_clk, fb;
  logic       up0, dn0, lock0, up1, dn1, lock1;
  logic [7:0] slip0, slip1;
  real        si0, si1;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  typedef struct {
    int  lead;
    int  up_w;
    int  dn_w;
    real si_p0;
    real si_p1;
  } vec_t;

  typedef struct {
    int         cyc;
    logic       up;
    logic       dn;
    logic       lock;
    logic [7:0] slip;
    real        si0;
    real        si1;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];

  pfd_cp_sampled u0 (
    .clk(clk), .rstb(rstb), .en(en), .ref_clk(ref_clk), .fb(fb),
    .up(up0), .dn(dn0), .si(si0), .lock(lock0), .slip_cnt(slip0)
  );

  pfd_cp_sampled #(.MISMATCH(0.1)) u1 (
    .clk(clk), .rstb(rstb), .en(en), .ref_clk(ref_clk), .fb(fb),
    .up(up1), .dn(dn1), .si(si1), .lock(lock1), .slip_cnt(slip1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk1(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0b required %0b", nm, $time, act, exp);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chkr(string nm, real act, real exp);
    n_cmp++;
    if ((act - exp > 1e-12) || (exp - act > 1e-12)) begin
      n_err++;
      $display("FAIL %s @%0t: actual %g required %g", nm, $time, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ref_pulse();
    ref_clk = 1'b1;
    tick(2);
    ref_clk = 1'b0;
    tick(2);
  endtask

  // Scoreboard consumer
  initial forever begin
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_late: entry for cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else begin
        chk1("sb_up0", up0, e.up);
        chk1("sb_dn0", dn0, e.dn);
        chk1("sb_up1", up1, e.up);
        chk1("sb_dn1", dn1, e.dn);
        chk1("sb_lock0", lock0, e.lock);
        chk1("sb_lock1", lock1, e.lock);
        chk8("sb_slip0", slip0, e.slip);
        chk8("sb_slip1", slip1, e.slip);
        chkr("sb_si0", si0, e.si0);
        chkr("sb_si1", si1, e.si1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   p, w, ra, fa;

    tbl[0] = '{5, 5, 0, 100e-6, 100e-6};
    tbl[1] = '{-3, 0, 3, -100e-6, -110e-6};
    tbl[2] = '{0, 0, 0, 0.0, 0.0};
    tbl[3] = '{1, 1, 0, 100e-6, 100e-6};
    tbl[4] = '{-1, 0, 1, -100e-6, -110e-6};
    tbl[5] = '{2, 2, 0, 100e-6, 100e-6};
    tbl[6] = '{-7, 0, 7, -100e-6, -110e-6};
    tbl[7] = '{3, 3, 0, 100e-6, 100e-6};

    rstb = 1'b0; en = 1'b1; ref_clk = 1'b0; fb = 1'b0;

    // Held in reset while the inputs toggle
    for (int i = 0; i < 10; i++) begin
      ref_clk = i[0];
      fb      = ~i[1];
      tick();
      chk1("rst_up", up0, 1'b0);
      chk1("rst_dn", dn0, 1'b0);
      chkr("rst_si", si0, 0.0);
      chk1("rst_lock", lock0, 1'b0);
      chk8("rst_slip", slip0, 8'd0);
    end
    ref_clk = 1'b0; fb = 1'b0;
    tick();
    rstb = 1'b1;
    tick(4);
    chk1("idle_up", up0, 1'b0);
    chk1("idle_dn", dn0, 1'b0);

    // Single lead/lag periods
    for (int v = 0; v < 8; v++) begin
      p  = cyc;
      w  = tbl[v].up_w + tbl[v].dn_w;
      ra = (tbl[v].lead >= 0) ? 0 : -tbl[v].lead;
      fa = (tbl[v].lead >= 0) ? tbl[v].lead : 0;
      for (int j = 0; j < 17; j++) begin
        e.cyc  = p + 3 + j;
        e.lock = 1'b0;
        e.slip = 8'd0;
        if (j < w) begin
          e.up  = (tbl[v].up_w > 0);
          e.dn  = (tbl[v].dn_w > 0);
          e.si0 = tbl[v].si_p0;
          e.si1 = tbl[v].si_p1;
        end else if (j < w + 2) begin
          e.up  = 1'b1;
          e.dn  = 1'b1;
          e.si0 = 0.0;
          e.si1 = -10e-6;
        end else begin
          e.up  = 1'b0;
          e.dn  = 1'b0;
          e.si0 = 0.0;
          e.si1 = 0.0;
        end
        sb.push_back(e);
      end
      for (int i = 0; i < 20; i++) begin
        ref_clk = (i >= ra) && (i < ra + 2);
        fb      = (i >= fa) && (i < fa + 2);
        tick();
      end
    end

    // Coincident edges: lock after exactly 64 good edges
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(2);
    for (int k = 0; k < 64; k++) begin
      e.cyc  = cyc + 3;
      e.up   = 1'b1;
      e.dn   = 1'b1;
      e.lock = (k == 63);
      e.slip = 8'd0;
      e.si0  = 0.0;
      e.si1  = -10e-6;
      sb.push_back(e);
      for (int i = 0; i < 8; i++) begin
        ref_clk = (i < 2);
        fb      = (i < 2);
        tick();
      end
    end
    chk1("lock_held", lock0, 1'b1);

    // Two ref edges without fb: slip and loss of lock
    ref_pulse();
    ref_pulse();
    tick(3);
    chk8("slip_first", slip0, 8'd1);
    chk1("slip_lock", lock0, 1'b0);
    chk1("slip_up", up0, 1'b1);
    chk1("slip_dn", dn0, 1'b0);
    for (int i = 0; i < 9; i++) ref_pulse();
    tick(3);
    chk8("slip_ten", slip0, 8'd10);
    for (int i = 0; i < 290; i++) ref_pulse();
    tick(3);
    chk8("slip_sat0", slip0, 8'd255);
    chk8("slip_sat1", slip1, 8'd255);
    fb = 1'b1;
    tick(2);
    fb = 1'b0;
    tick();
    chk1("slip_exit_up", up0, 1'b1);
    chk1("slip_exit_dn", dn0, 1'b1);
    chkr("slip_exit_si1", si1, -10e-6);
    tick(4);
    chk1("slip_idle_up", up0, 1'b0);
    chk1("slip_idle_dn", dn0, 1'b0);

    // Enable dropped during UP
    ref_clk = 1'b1;
    tick(2);
    ref_clk = 1'b0;
    tick();
    chk1("en_up_before", up0, 1'b1);
    chkr("en_si_before", si0, 100e-6);
    en = 1'b0;
    tick();
    chk1("en_up_after", up0, 1'b0);
    chkr("en_si0_after", si0, 0.0);
    chkr("en_si1_after", si1, 0.0);
    chk1("en_lock_after", lock0, 1'b0);
    chk8("en_slip_held", slip0, 8'd255);
    en = 1'b1;
    tick(4);
    chk1("en_resume_up", up0, 1'b0);

    // Asynchronous reset in the middle of a DN pulse
    fb = 1'b1;
    tick(2);
    fb = 1'b0;
    tick();
    chk1("arst_dn_before", dn0, 1'b1);
    chkr("arst_si1_before", si1, -110e-6);
    rstb = 1'b0;
    #1;
    chk1("arst_dn", dn0, 1'b0);
    chkr("arst_si0", si0, 0.0);
    chkr("arst_si1", si1, 0.0);
    chk8("arst_slip", slip0, 8'd0);
    chk1("arst_lock", lock0, 1'b0);
    tick(2);
    rstb = 1'b1;
    tick(3);
    chk1("post_rst_up", up0, 1'b0);
    chk1("post_rst_dn", dn0, 1'b0);

    tick(2);
    chk8("sb_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
